// File: rtl/prbs_wide_gen.sv
// Parallel PRBS-PN generator: each enabled cycle emits WIDTH consecutive sequence
// bits (bit 0 earliest) and their registered bitwise complement.
module prbs_wide_gen #(
  parameter int PN    = 7,
  parameter int WIDTH = 128
) (
  input  logic             i_clk,
  input  logic             i_s_rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_prbs,
  output logic [WIDTH-1:0] o_prbs_n
);

  // Second feedback tap for each supported order; the first tap is always PN.
  function automatic int tap_b(input int pn);
    case (pn)
      7:       return 6;
      9:       return 5;
      11:      return 9;
      15:      return 14;
      20:      return 3;
      23:      return 18;
      31:      return 28;
      default: return 1;
    endcase
  endfunction

  localparam int TAP_A = PN;
  localparam int TAP_B = tap_b(PN);

  if (!(PN == 7 || PN == 9 || PN == 11 || PN == 15 ||
        PN == 20 || PN == 23 || PN == 31)) begin : g_bad_pn
    $error("prbs_wide_gen: unsupported PN order %0d", PN);
  end

  if (WIDTH < 1) begin : g_bad_width
    $error("prbs_wide_gen: WIDTH must be at least 1, got %0d", WIDTH);
  end

  logic [PN-1:0]    s_q, s_d;
  logic [WIDTH-1:0] prbs_q, prbs_d;
  logic [WIDTH-1:0] prbs_n_q;

  // NOTE: blocking assignments inside this loop are intentional: each unrolled
  // step must see the state produced by the previous step in the same cycle.
  always_comb begin
    s_d    = s_q;
    prbs_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      prbs_d[i] = s_d[TAP_A-1] ^ s_d[TAP_B-1];
      s_d       = {s_d[PN-2:0], prbs_d[i]};
    end
  end

  // The complement is registered from the same next value so both outputs stay
  // exactly complementary; both read 0 in reset as a "no data" marker.
  always_ff @(posedge i_clk or negedge i_s_rst_n) begin
    if (!i_s_rst_n) begin
      s_q      <= '1;
      prbs_q   <= '0;
      prbs_n_q <= '0;
    end else if (i_en) begin
      s_q      <= s_d;
      prbs_q   <= prbs_d;
      prbs_n_q <= ~prbs_d;
    end
  end

  assign o_prbs   = prbs_q;
  assign o_prbs_n = prbs_n_q;

endmodule

// File: tb/tb_prbs_wide_gen.sv
// Self-checking bench for prbs_wide_gen: scoreboarded PN7/128 instance plus a
// PN x WIDTH sweep of instances checked against bit-serial reference LFSRs.
module tb_prbs_wide_gen;

  typedef struct {
    logic [127:0] prbs;
    logic [127:0] prbs_n;
  } exp_t;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         en    = 1'b0;
  logic [127:0] prbs, prbs_n;

  int n_checks      = 0;
  int n_fail        = 0;
  int periods_found = 0;
  bit sweep_on      = 1'b0;

  exp_t         exp_q[$];
  logic [127:0] hist[$];
  logic [6:0]   m_s    = '1;
  logic [127:0] m_word = '0;

  always #5 clk = ~clk;

  prbs_wide_gen #(.PN(7), .WIDTH(128)) u_dut (
    .i_clk    (clk),
    .i_s_rst_n(rst_n),
    .i_en     (en),
    .o_prbs   (prbs),
    .o_prbs_n (prbs_n)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int pn_of(input int k);
    case (k)
      0:       return 7;
      1:       return 9;
      2:       return 11;
      3:       return 15;
      4:       return 20;
      5:       return 23;
      default: return 31;
    endcase
  endfunction

  function automatic int tapb_of(input int p);
    case (p)
      7:       return 6;
      9:       return 5;
      11:      return 9;
      15:      return 14;
      20:      return 3;
      23:      return 18;
      default: return 28;
    endcase
  endfunction

  function automatic int w_of(input int k, input int p);
    case (k)
      0:       return 1;
      1:       return 8;
      2:       return p;
      default: return 128;
    endcase
  endfunction

  // Sweep: every supported order at widths 1, 8, PN and 128, each with its own
  // serial reference LFSR following the shared enable/reset.
  for (genvar gi = 0; gi < 7; gi++) begin : g_pn
    for (genvar wi = 0; wi < 4; wi++) begin : g_w
      localparam int P  = pn_of(gi);
      localparam int W  = w_of(wi, P);
      localparam int TB = tapb_of(P);

      logic [W-1:0] sp, spn;
      logic [30:0]  rs;
      logic [127:0] ew, ewn, got, got_n;
      logic         b;
      bit           en_edge;
      int           n_en;

      prbs_wide_gen #(.PN(P), .WIDTH(W)) u_sw (
        .i_clk    (clk),
        .i_s_rst_n(rst_n),
        .i_en     (en),
        .o_prbs   (sp),
        .o_prbs_n (spn)
      );

      always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rs = '1; ew = '0; ewn = '0; en_edge = 1'b0; n_en = 0;
        end else if (en) begin
          for (int i = 0; i < W; i++) begin
            b     = rs[P-1] ^ rs[TB-1];
            ew[i] = b;
            rs    = {rs[29:0], b};
          end
          ewn = '0;
          ewn[W-1:0] = ~ew[W-1:0];
          en_edge = 1'b1;
          n_en++;
        end else begin
          en_edge = 1'b0;
        end
      end

      always @(negedge clk) begin
        if (sweep_on) begin
          got   = '0; got[W-1:0]   = sp;
          got_n = '0; got_n[W-1:0] = spn;
          check($sformatf("pn%0d_w%0d", P, W), got, ew);
          check($sformatf("pn%0d_w%0d_n", P, W), got_n, ewn);
        end
      end

      // With WIDTH == PN a word is the whole state, so the first word recurs
      // exactly one sequence period later.
      if (P <= 15 && W == P) begin : g_per
        logic [127:0] first_w, cur_w;
        bit           done = 1'b0;
        always @(negedge clk) begin
          if (sweep_on && rst_n && en_edge) begin
            cur_w = '0; cur_w[W-1:0] = sp;
            if (n_en == 1) first_w = cur_w;
            else if (!done && cur_w == first_w) begin
              check($sformatf("period_pn%0d", P), 128'(n_en - 1), 128'((1 << P) - 1));
              done = 1'b1;
              periods_found++;
            end
          end
        end
      end
    end
  end

  task automatic model_step(input logic e);
    logic bb;
    if (rst_n && e) begin
      for (int i = 0; i < 128; i++) begin
        bb        = m_s[6] ^ m_s[5];
        m_word[i] = bb;
        m_s       = {m_s[5:0], bb};
      end
    end
  endtask

  // Drive one cycle: push the expected registered outputs, then compare after the edge.
  task automatic cycle(input logic e);
    exp_t x;
    en = e;
    model_step(e);
    x.prbs   = m_word;
    x.prbs_n = rst_n ? ~m_word : '0;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
    x = exp_q.pop_front();
    check("prbs", prbs, x.prbs);
    check("prbs_n", prbs_n, x.prbs_n);
  endtask

  task automatic check_recurrence(input logic [127:0] prev, input logic [127:0] w);
    logic [127:0] pred;
    for (int i = 0; i < 128; i++) begin
      pred[i] = (i >= 7 ? w[i-7] : prev[121+i]) ^ (i >= 6 ? w[i-6] : prev[122+i]);
    end
    check("recur", w, pred);
  endtask

  initial begin
    logic [127:0] prev;
    #2 rst_n = 1'b0;
    #1;
    check("rst_prbs", prbs, '0);
    check("rst_prbs_n", prbs_n, '0);
    sweep_on = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    cycle(1'b1);
    check("first7", {121'b0, prbs[6:0]}, 128'h40);

    prev = prbs;
    hist.push_back(prbs);
    for (int k = 0; k < 1000; k++) begin
      cycle(1'b1);
      check_recurrence(prev, prbs);
      hist.push_back(prbs);
      if (hist.size() >= 128) check("per127", prbs, hist[hist.size()-128]);
      prev = prbs;
    end

    repeat (2) begin
      repeat (127) cycle(1'b1);
      repeat (127) cycle(1'b0);
    end
    for (int i = 0; i < 60; i++) cycle(i[0]);
    repeat (300) cycle(1'($urandom_range(0, 1)));

    // Asynchronous reset between edges, held across an enabled edge.
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_prbs", prbs, '0);
    check("mid_rst_prbs_n", prbs_n, '0);
    m_s    = '1;
    m_word = '0;
    cycle(1'b1);
    #2 rst_n = 1'b1;
    cycle(1'b1);
    check("restart7", {121'b0, prbs[6:0]}, 128'h40);

    repeat (33000) cycle(1'b1);
    check("periods", 128'(periods_found), 128'd4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prbs_wide_gen.md
# prbs_wide_gen

Parallel pseudo-random binary sequence generator. Each enabled clock cycle it produces WIDTH consecutive bits of an ITU-T O.150-style PRBS-PN sequence, plus the bitwise complement. It is used as a wide test-pattern source for serializer, link and BER-checker datapaths. The module is named `prbs_wide_gen`.

## Interface
Parameters:
- PN, default 7: PRBS order. Supported values are 7, 9, 11, 15, 20, 23 and 31. Any other value is an elaboration error (`$error`).
- WIDTH, default 128: output word width in bits, WIDTH ≥ 1. WIDTH need not relate to PN.

Ports:
- i_clk, input, 1: single clock. All logic is on its rising edge.
- i_s_rst_n, input, 1: reset, asynchronous and active-low.
- i_en, input, 1: advance enable. When high, one new word is produced per cycle.
- o_prbs, output, WIDTH: PRBS word, registered. Bit 0 is the earliest bit in sequence order.
- o_prbs_n, output, WIDTH: bitwise complement of o_prbs, registered.

## Operation
Polynomials (taps A, B):
- PN7: x^7+x^6+1, taps (7,6)
- PN9: x^9+x^5+1, taps (9,5)
- PN11: x^11+x^9+1, taps (11,9)
- PN15: x^15+x^14+1, taps (15,14)
- PN20: x^20+x^3+1, taps (20,3)
- PN23: x^23+x^18+1, taps (23,18)
- PN31: x^31+x^28+1, taps (31,28)

Sequence generation:
- State register s[PN-1:0] holds the last PN sequence bits, with s[0] the newest.
- One serial step computes b = s[A-1] ^ s[B-1], then s <= {s[PN-2:0], b}. Equivalently, bit_n = bit_(n-A) ^ bit_(n-B).
- Seed is all ones. Per step, b is emitted as the next sequence bit, non-inverted.
- Per enabled cycle, WIDTH serial steps are unrolled combinationally from the current s:
  - o_prbs[i] <= bit produced at step i+1.
  - s <= state after WIDTH steps.
- o_prbs_n <= ~next o_prbs, registered in the same edge so it is exactly complementary.
- i_en low: s, o_prbs and o_prbs_n all hold.
- The all-zero state is unreachable from the seed; no lock-up recovery logic is required.
- Sequence period is 2^PN − 1 bits. The word sequence repeats every (2^PN − 1)/gcd(WIDTH, 2^PN − 1) enabled cycles: 127 cycles for PN7 with WIDTH=128.

## Timing
- Reset asserted (async, immediate): s = all ones, o_prbs = 0, o_prbs_n = 0.
  - o_prbs_n is 0 during reset, not all ones. This is a deliberate "no data" indication.
- First rising edge with reset released and i_en=1 loads word 0 (sequence bits 1..WIDTH). Latency is one cycle from i_en to a new word.
- Each further enabled edge loads the next WIDTH bits with no gap. Disabled edges insert no bits and skip none.
- An i_en toggle on any cycle: the next enabled edge continues exactly where the sequence stopped.
- Reset asserted mid-operation: outputs clear immediately. After release the sequence restarts from word 0.
- Reset and i_en high together: reset wins.

## Test plan
- Reset, then i_en=1 for one edge (PN7, WIDTH=128): o_prbs[6:0] = 7'h40, i.e. first six bits 0 and the seventh 1. o_prbs_n = ~o_prbs.
- Continuous enable for 1000 cycles: every word satisfies o_prbs[i] = o_prbs[i-7] ^ o_prbs[i-6] for i ≥ 7. The link across the word boundary is checked against the previous word. The word at cycle k+127 equals the word at cycle k.
- Toggle i_en every 127 cycles, as well as single-cycle and random patterns: concatenating the words from enabled edges only gives the same bitstream as continuous enable. Outputs stay stable while i_en=0.
- Assert i_s_rst_n mid-stream between clock edges: o_prbs and o_prbs_n become 0 without a clock edge. After release, the first enabled word again has o_prbs[6:0] = 7'h40.
- Sweep PN ∈ {7, 9, 11, 15, 20, 23, 31} and WIDTH ∈ {1, 8, PN, 128}: the stream matches a bit-serial reference LFSR with the listed taps. The period equals 2^PN − 1 (checked for PN ≤ 15). PN=8 fails elaboration.
